piece_input_ctrl: RTL and testbench
===================================

# piece_input_ctrl

Front end of the piece-control state machine. Converts the raw 8-bit keyboard keycode into single-cycle, handshaked move commands, with delayed auto-shift (DAS) on held left/right keys. It also generates the frame tick and the gravity `fall_tick` that drives the state machine's fall path, and detects the Konami sequence. It sits between the keyboard/USB keycode register and the piece-control state machine.

## Interface
Parameters:
- `TICK_DIV`, 833333: Clk cycles per frame (50 MHz / 60 Hz).
- `DAS_FRAMES`, 10: frames a left/right key is held before auto-repeat starts.
- `ARR_FRAMES`, 2: frames between auto-repeat commands.
- `GRAVITY_BASE`, 48: frames per fall at level 0.
- `GRAVITY_STEP`, 4: frames removed per level.

Ports:
- `Clk` in 1: the single clock; all logic is on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `keycode` in 8: current HID keycode, 0 = no key.
- `level` in 4: game level, sampled at each frame tick.
- `cmd_ready` in 1: the state machine accepts `cmd` this cycle.
- `cmd_valid` out 1: `cmd` is pending.
- `cmd` out 3: 1 LEFT, 2 RIGHT, 3 ROT_L, 4 ROT_R, 5 HOLD, 6 KONAMI, 7 HARD_DROP. Value 0 is never issued.
- `frame_tick` out 1: one-cycle pulse per frame.
- `fall_tick` out 1: one-cycle gravity pulse.

## Operation
- **Prescaler:** `div_cnt` runs 0..`TICK_DIV`-1. `frame_tick`=1 in the cycle `div_cnt`==`TICK_DIV`-1, then the counter wraps to 0.
- **Key edge:** `key_q` registers `keycode` every cycle. A new press is `keycode`!=0 && `keycode`!=`key_q`. A key change counts as a new press with no intervening 0 required.
- **Keycode map:**
  - 0x50 LEFT, 0x4F RIGHT, 0x1D ROT_L, 0x1B ROT_R, 0x06 HOLD, 0x2C HARD_DROP.
  - 0x51 (down) is soft drop and is not a command.
  - Unmapped keys produce no command.
- **One-shot keys:** ROT_L, ROT_R, HOLD and HARD_DROP issue exactly one command per new press.
- **DAS (LEFT/RIGHT):**
  - A new press issues the command immediately and clears `das_cnt`.
  - While the same key stays held, `das_cnt` increments on each `frame_tick`.
  - When `das_cnt` reaches `DAS_FRAMES`, the command repeats. After that it repeats every `ARR_FRAMES` frames.
  - Release or key change stops repeat.
- **Output register:**
  - Single entry. `cmd_valid`/`cmd` hold stable until the cycle `cmd_valid`&&`cmd_ready`.
  - A command generated while one is pending is dropped. Counters still advance.
  - Accept and a new event in the same cycle: the new command loads, so `cmd_valid` stays 1.
- **Gravity:**
  - period = `GRAVITY_BASE` − `GRAVITY_STEP`×`level`, computed 8-bit, saturated to a minimum of 1.
  - period = 1 while `keycode`==0x51.
  - `grav_cnt` increments on `frame_tick`. When `grav_cnt`+1 >= period, `fall_tick` pulses in that `frame_tick` cycle and `grav_cnt` clears.
  - Period shrinking below `grav_cnt` fires at the next frame tick.
  - `fall_tick` ignores `cmd_ready`.
- **Konami matcher:**
  - 4-bit `k_step` steps through the sequence 0x52,0x52,0x51,0x51,0x50,0x4F,0x50,0x4F,0x05,0x04, advancing only on new presses.
  - On a match at step 9, it issues KONAMI and returns to 0.
  - Mismatch rules:
    - 0x52 at step 2 stays at 2.
    - Any other 0x52 goes to 1.
    - Anything else goes to 0.
  - Arrow presses inside the sequence still issue their normal commands.

## Timing
- **Reset:** all outputs 0. `div_cnt`, `das_cnt`, `grav_cnt`, `k_step`, `key_q` are all 0. `RESET` mid-operation discards any pending command the next cycle.
- **Command latency:** a new press at cycle N (keycode visible) drives `cmd_valid`=1 at N+1.
- **DAS repeat:** occurs in the cycle after the qualifying `frame_tick`.
- **Ready-held-high throughput:** one command per cycle maximum.
- **Simultaneous events:** KONAMI completion takes priority over a LEFT/RIGHT repeat in the same cycle.
- **Tick alignment:** `fall_tick` is always coincident with `frame_tick`.

## Configuration
- `KONAMI_DETECT_EN`:
  - Defined: the matcher is built and cmd 6 can be issued.
  - Undefined: no `k_step` register, cmd 6 is never issued, and the interface is unchanged.

## Test plan
- **DAS repeat:** set `TICK_DIV`=4, `DAS_FRAMES`=2, `ARR_FRAMES`=1, `cmd_ready`=1; hold 0x50 for 6 frames. Expect LEFT at press+1, then one LEFT per frame starting after frame 2.
- **Backpressure:** `cmd_ready`=0; press 0x1D then 0x1B. Expect `cmd`=3 held stable and ROT_R dropped; raise `cmd_ready` and expect `cmd_valid` to fall the next cycle.
- **Gravity:** `level`=11 at `GRAVITY_BASE` 48 gives period 4, so `fall_tick` fires every 4th `frame_tick`. `level`=15 saturates to period 1. Holding 0x51 fires every frame.
- **Konami:** the 10-key sequence with an extra leading 0x52 yields exactly one cmd 6 after 0x04. With the macro undefined, no cmd 6 is issued.
- **Reset and one-shots:** assert `RESET` with `cmd_valid`=1 → all outputs 0 next cycle. Holding 0x06 for 100 frames → exactly one HOLD.

Source files
------------

// File: rtl/piece_input_ctrl.sv
// Keyboard front end for the piece-control state machine: edge-detected, handshaked move
// commands with DAS auto-shift, frame/gravity ticks. Konami matcher built under KONAMI_DETECT_EN.
module piece_input_ctrl #(
  parameter int unsigned TICK_DIV     = 833333,
  parameter int unsigned DAS_FRAMES   = 10,
  parameter int unsigned ARR_FRAMES   = 2,
  parameter int unsigned GRAVITY_BASE = 48,
  parameter int unsigned GRAVITY_STEP = 4
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic [7:0] keycode,
  input  logic [3:0] level,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       frame_tick,
  output logic       fall_tick
);

  typedef enum logic [2:0] {
    CmdNone     = 3'd0,
    CmdLeft     = 3'd1,
    CmdRight    = 3'd2,
    CmdRotL     = 3'd3,
    CmdRotR     = 3'd4,
    CmdHold     = 3'd5,
    CmdKonami   = 3'd6,
    CmdHardDrop = 3'd7
  } cmd_e;

  localparam logic [7:0] KeyLeft     = 8'h50;
  localparam logic [7:0] KeyRight    = 8'h4F;
  localparam logic [7:0] KeyRotL     = 8'h1D;
  localparam logic [7:0] KeyRotR     = 8'h1B;
  localparam logic [7:0] KeyHold     = 8'h06;
  localparam logic [7:0] KeyHardDrop = 8'h2C;
  localparam logic [7:0] KeySoftDrop = 8'h51;

  localparam int unsigned DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam int unsigned DasW     = $clog2(DAS_FRAMES + ARR_FRAMES + 1);
  localparam logic [DasW-1:0] DasFirst = DasW'(DAS_FRAMES);
  localparam logic [DasW-1:0] DasNext  = DasW'(DAS_FRAMES + ARR_FRAMES);
  localparam logic [11:0] GravBase = 12'(GRAVITY_BASE);
  localparam logic [11:0] GravStep = 12'(GRAVITY_STEP);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]      key_q;
  logic [DasW-1:0] das_cnt_q, das_cnt_d;
  logic [7:0]      grav_cnt_q, grav_cnt_d;
  logic            cmd_valid_q, cmd_valid_d;
  cmd_e            cmd_q, cmd_d;

  logic            new_press;
  logic            key_held;
  cmd_e            press_cmd;
  logic            is_lr;
  logic            das_rpt;
  logic [DasW-1:0] das_inc;
  logic            konami_hit;
  cmd_e            ev_cmd;
  logic [11:0]     grav_drop;
  logic [7:0]      grav_period;
  logic [8:0]      grav_inc;

  // Prescaler
  assign frame_tick = (div_cnt_q == DivLast);
  assign div_cnt_d  = frame_tick ? '0 : div_cnt_q + 1'b1;

  // Key edge detection; a direct key change is a fresh press
  assign new_press = (keycode != 8'h00) && (keycode != key_q);
  assign key_held  = (keycode != 8'h00) && (keycode == key_q);

  always_comb begin
    press_cmd = CmdNone;
    case (keycode)
      KeyLeft:     press_cmd = CmdLeft;
      KeyRight:    press_cmd = CmdRight;
      KeyRotL:     press_cmd = CmdRotL;
      KeyRotR:     press_cmd = CmdRotR;
      KeyHold:     press_cmd = CmdHold;
      KeyHardDrop: press_cmd = CmdHardDrop;
      default:     press_cmd = CmdNone;
    endcase
  end

  assign is_lr   = (press_cmd == CmdLeft) || (press_cmd == CmdRight);
  assign das_inc = das_cnt_q + 1'b1;

  // DAS: first repeat at DasFirst frames, then the counter bounces between DasFirst and DasNext
  always_comb begin
    das_cnt_d = das_cnt_q;
    das_rpt   = 1'b0;
    if (new_press) begin
      das_cnt_d = '0;
    end else if (is_lr && key_held && frame_tick) begin
      if (das_inc == DasFirst) begin
        das_cnt_d = das_inc;
        das_rpt   = 1'b1;
      end else if (das_inc == DasNext) begin
        das_cnt_d = DasFirst;
        das_rpt   = 1'b1;
      end else begin
        das_cnt_d = das_inc;
      end
    end
  end

`ifdef KONAMI_DETECT_EN
  logic [3:0] k_step_q, k_step_d;

  function automatic logic [7:0] k_code(input logic [3:0] step);
    case (step)
      4'd0, 4'd1: k_code = 8'h52;
      4'd2, 4'd3: k_code = 8'h51;
      4'd4, 4'd6: k_code = 8'h50;
      4'd5, 4'd7: k_code = 8'h4F;
      4'd8:       k_code = 8'h05;
      default:    k_code = 8'h04;
    endcase
  endfunction

  always_comb begin
    k_step_d   = k_step_q;
    konami_hit = 1'b0;
    if (new_press) begin
      if (keycode == k_code(k_step_q)) begin
        if (k_step_q == 4'd9) begin
          konami_hit = 1'b1;
          k_step_d   = 4'd0;
        end else begin
          k_step_d = k_step_q + 4'd1;
        end
      end else if (keycode == 8'h52) begin
        // A third "up" still leaves two valid leading ups
        k_step_d = (k_step_q == 4'd2) ? 4'd2 : 4'd1;
      end else begin
        k_step_d = 4'd0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      k_step_q <= 4'd0;
    end else begin
      k_step_q <= k_step_d;
    end
  end
`else
  assign konami_hit = 1'b0;
`endif

  // Event priority: Konami completion, then fresh press, then auto-repeat
  always_comb begin
    ev_cmd = CmdNone;
    if (konami_hit) begin
      ev_cmd = CmdKonami;
    end else if (new_press || das_rpt) begin
      ev_cmd = press_cmd;
    end
  end

  // Single-entry output register; a new event while blocked is dropped
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    if ((ev_cmd != CmdNone) && (!cmd_valid_q || cmd_ready)) begin
      cmd_valid_d = 1'b1;
      cmd_d       = ev_cmd;
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      cmd_d       = CmdNone;
    end
  end

  // Gravity period, saturated to 1; soft drop forces every frame
  always_comb begin
    grav_drop = GravStep * {8'h00, level};
    if (keycode == KeySoftDrop) begin
      grav_period = 8'd1;
    end else if (grav_drop >= GravBase) begin
      grav_period = 8'd1;
    end else begin
      grav_period = 8'(GravBase - grav_drop);
    end
  end

  assign grav_inc  = {1'b0, grav_cnt_q} + 9'd1;
  assign fall_tick = frame_tick && (grav_inc >= {1'b0, grav_period});

  always_comb begin
    grav_cnt_d = grav_cnt_q;
    if (frame_tick) begin
      grav_cnt_d = fall_tick ? 8'd0 : grav_inc[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      div_cnt_q   <= '0;
      key_q       <= 8'h00;
      das_cnt_q   <= '0;
      grav_cnt_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CmdNone;
    end else begin
      div_cnt_q   <= div_cnt_d;
      key_q       <= keycode;
      das_cnt_q   <= das_cnt_d;
      grav_cnt_q  <= grav_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;

endmodule

// File: tb/tb_piece_input_ctrl.sv
// Directed bench for piece_input_ctrl with a short frame (TICK_DIV=4, DAS 2, ARR 1).
module tb_piece_input_ctrl;

  logic       Clk;
  logic       RESET;
  logic [7:0] keycode;
  logic [3:0] level;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       frame_tick;
  logic       fall_tick;

  int n_asrt = 0;
  int n_fail = 0;

  int cmd_cnt [8] = '{default: 0};
  int n_frame = 0;
  int n_fall = 0;
  int n_misalign = 0;

  int base_a, base_b, base_c, base_d;
  int exp_konami;

  piece_input_ctrl #(
    .TICK_DIV    (4),
    .DAS_FRAMES  (2),
    .ARR_FRAMES  (1),
    .GRAVITY_BASE(48),
    .GRAVITY_STEP(4)
  ) dut (
    .Clk       (Clk),
    .RESET     (RESET),
    .keycode   (keycode),
    .level     (level),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .frame_tick(frame_tick),
    .fall_tick (fall_tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bench-side event counters, sampled mid-cycle
  always @(negedge Clk) begin
    if (!RESET) begin
      if (cmd_valid && cmd_ready) cmd_cnt[cmd] = cmd_cnt[cmd] + 1;
      if (frame_tick) n_frame = n_frame + 1;
      if (fall_tick) n_fall = n_fall + 1;
      if (fall_tick && !frame_tick) n_misalign = n_misalign + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asrt++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    step(2);
    keycode = 8'h00;
    step(2);
  endtask

  function automatic int total_cmds();
    int s = 0;
    for (int i = 0; i < 8; i++) s += cmd_cnt[i];
    return s;
  endfunction

  initial begin
    RESET     = 1'b1;
    keycode   = 8'h00;
    level     = 4'd0;
    cmd_ready = 1'b1;
`ifdef KONAMI_DETECT_EN
    exp_konami = 1;
`else
    exp_konami = 0;
`endif

    step(3);
    @(negedge Clk);
    chk("rst_valid", {31'd0, cmd_valid}, 0);
    chk("rst_cmd", {29'd0, cmd}, 0);
    chk("rst_frame", {31'd0, frame_tick}, 0);
    chk("rst_fall", {31'd0, fall_tick}, 0);

    // Latency: press in cycle N, valid in N+1, gone after accept
    step(1);
    RESET   = 1'b0;
    keycode = 8'h1D;
    @(negedge Clk);
    chk("lat_same_cycle", {31'd0, cmd_valid}, 0);
    step(1);
    @(negedge Clk);
    chk("lat_valid", {31'd0, cmd_valid}, 1);
    chk("lat_cmd", {29'd0, cmd}, 3);
    step(1);
    @(negedge Clk);
    chk("oneshot_clear", {31'd0, cmd_valid}, 0);
    keycode = 8'h00;
    step(2);

    // Backpressure: ROT_L held, ROT_R dropped
    cmd_ready = 1'b0;
    keycode   = 8'h1D;
    step(1);
    @(negedge Clk);
    chk("bp_first", {29'd0, cmd}, 3);
    keycode = 8'h1B;
    step(3);
    @(negedge Clk);
    chk("bp_hold_valid", {31'd0, cmd_valid}, 1);
    chk("bp_hold_cmd", {29'd0, cmd}, 3);
    step(1);
    cmd_ready = 1'b1;
    @(negedge Clk);
    chk("bp_accept_cmd", {29'd0, cmd}, 3);
    step(1);
    @(negedge Clk);
    chk("bp_dropped", {31'd0, cmd_valid}, 0);
    keycode = 8'h00;
    step(2);

    // Accept and new event in the same cycle
    keycode = 8'h06;
    step(1);
    @(negedge Clk);
    chk("acc_hold", {29'd0, cmd}, 5);
    keycode = 8'h2C;
    step(1);
    @(negedge Clk);
    chk("acc_reload_valid", {31'd0, cmd_valid}, 1);
    chk("acc_reload_cmd", {29'd0, cmd}, 7);

    // HOLD held 100 frames issues once
    step(1);
    base_a  = cmd_cnt[5];
    keycode = 8'h06;
    step(400);
    keycode = 8'h00;
    step(4);
    chk("hold_once", cmd_cnt[5] - base_a, 1);

    // DAS: held for 24 cycles past the press -> 6 frame ticks -> 1 + 5 repeats
    base_a  = cmd_cnt[1];
    keycode = 8'h50;
    step(1);
    @(negedge Clk);
    chk("das_first_cmd", {29'd0, cmd}, 1);
    step(24);
    keycode = 8'h00;
    step(8);
    chk("das_count", cmd_cnt[1] - base_a, 6);

    // Gravity at level 11: period 4
    level = 4'd11;
    step(8);
    base_a = n_fall;
    base_b = n_frame;
    step(64);
    chk("frame_count", n_frame - base_b, 16);
    chk("grav_lvl11", n_fall - base_a, 4);
    level  = 4'd15;
    base_a = n_fall;
    step(32);
    chk("grav_lvl15", n_fall - base_a, 8);
    level   = 4'd0;
    keycode = 8'h51;
    base_a  = n_fall;
    base_b  = total_cmds();
    step(32);
    chk("grav_soft", n_fall - base_a, 8);
    chk("soft_no_cmd", total_cmds() - base_b, 0);
    keycode = 8'h00;
    base_a  = n_fall;
    step(32);
    chk("grav_lvl0", n_fall - base_a, 0);
    chk("tick_align", n_misalign, 0);

    // Konami with an extra leading up
    base_a = cmd_cnt[6];
    base_b = cmd_cnt[1];
    base_c = cmd_cnt[2];
    base_d = total_cmds();
    press(8'h52); press(8'h52); press(8'h52);
    press(8'h51); press(8'h51);
    press(8'h50); press(8'h4F); press(8'h50); press(8'h4F);
    press(8'h05); press(8'h04);
    step(4);
    chk("konami", cmd_cnt[6] - base_a, exp_konami);
    chk("konami_left", cmd_cnt[1] - base_b, 2);
    chk("konami_right", cmd_cnt[2] - base_c, 2);
    chk("konami_total", total_cmds() - base_d, 4 + exp_konami);

    // Reset with a pending command
    cmd_ready = 1'b0;
    keycode   = 8'h1B;
    step(1);
    @(negedge Clk);
    chk("pre_rst_cmd", {29'd0, cmd}, 4);
    RESET   = 1'b1;
    keycode = 8'h00;
    step(1);
    @(negedge Clk);
    chk("mid_rst_valid", {31'd0, cmd_valid}, 0);
    chk("mid_rst_cmd", {29'd0, cmd}, 0);
    chk("mid_rst_frame", {31'd0, frame_tick}, 0);
    chk("mid_rst_fall", {31'd0, fall_tick}, 0);
    step(1);
    RESET = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
